// File: rtl/mem_wb_bus_master_pkg.sv
// Shared definitions for the data-side Wishbone master.
// Contents: FSM state encoding, Wishbone bus widths, reset/stall constants,
// and the registered bus-request bundle that drives the wb_* outputs.
package mem_wb_bus_master_pkg;

  localparam int unsigned WbAdrW = 32;
  localparam int unsigned WbDatW = 32;
  localparam int unsigned WbSelW = 4;
  localparam int unsigned StallW = 6;

  localparam logic [WbDatW-1:0] ZeroWord  = '0;
  localparam logic              RstEnable = 1'b1;
  localparam logic              Stop      = 1'b1;
  localparam logic              NoStop    = 1'b0;

  typedef enum logic [1:0] {
    IDLE           = 2'b00,
    BUSY           = 2'b01,
    WAIT_FOR_STALL = 2'b10
  } bus_state_t;

  // Everything the master drives onto the bus, registered as one unit so the
  // classic-cycle rule (outputs frozen while waiting for ack) is a plain hold.
  typedef struct packed {
    logic [WbAdrW-1:0] adr;
    logic [WbDatW-1:0] dat;
    logic              we;
    logic [WbSelW-1:0] sel;
    logic              stb;
    logic              cyc;
  } wb_req_t;

endpackage

// File: rtl/mem_wb_bus_master_if.sv
// Wishbone classic bus bundle between the data-side master and a slave.
// master modport: drives adr/dat/we/sel/stb/cyc, receives dat_i/ack_i.
// slave modport : the mirror image.
interface mem_wb_bus_master_if;

  logic [mem_wb_bus_master_pkg::WbAdrW-1:0] wb_adr_o;
  logic [mem_wb_bus_master_pkg::WbDatW-1:0] wb_dat_o;
  logic                                     wb_we_o;
  logic [mem_wb_bus_master_pkg::WbSelW-1:0] wb_sel_o;
  logic                                     wb_stb_o;
  logic                                     wb_cyc_o;
  logic [mem_wb_bus_master_pkg::WbDatW-1:0] wb_dat_i;
  logic                                     wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i
  );

endinterface

// File: rtl/mem_bus_timeout.sv
// 8-bit saturating cycle counter used to bound how long a bus access may wait
// for ack.
// Ports: clk, rst (sync, active-high), clr (zero the count, wins over en),
//        en (count up, saturating at 255), expired (count == LIMIT-1).
module mem_bus_timeout
  import mem_wb_bus_master_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] Last = 8'(LIMIT - 1);

  logic [7:0] count_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      count_q <= 8'd0;
    end else if (clr) begin
      count_q <= 8'd0;
    end else if (en && (count_q != 8'hFF)) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign expired = (count_q == Last);

endmodule

// File: rtl/mem_wb_bus_master.sv
// Data-side Wishbone master behind the EX/MEM register.
// Takes a load/store request from the memory stage, runs one classic Wishbone
// cycle for it, and stalls the pipeline until the access completes. Load data
// is forwarded in the ack cycle and then held in rd_buf while other stall
// sources keep the pipeline frozen. A flush aborts the access; a missing ack
// is terminated after TIMEOUT_CYCLES with ERR_DATA and a bus_err_o pulse.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall_i, flush_i         pipeline stall vector and flush
//   cpu_ce_i/addr/we/sel/data_i  memory-stage request
//   cpu_data_o               load data to the memory stage
//   stallreq                 stall request to the pipeline controller
//   bus_err_o                one-cycle pulse after a timeout
//   wb                       Wishbone master modport
module mem_wb_bus_master
  import mem_wb_bus_master_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYCLES = 255,
  parameter logic [WbDatW-1:0] ERR_DATA       = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [StallW-1:0]   stall_i,
  input  logic                flush_i,
  input  logic                cpu_ce_i,
  input  logic [WbAdrW-1:0]   cpu_addr_i,
  input  logic                cpu_we_i,
  input  logic [WbSelW-1:0]   cpu_sel_i,
  input  logic [WbDatW-1:0]   cpu_data_i,
  output logic [WbDatW-1:0]   cpu_data_o,
  output logic                stallreq,
  output logic                bus_err_o,
  mem_wb_bus_master_if.master wb
);

  bus_state_t        state_q, state_d;
  wb_req_t           req_q, req_d;
  logic [WbDatW-1:0] rd_buf_q, rd_buf_d;
  logic              bus_err_q, bus_err_d;
  logic              tmo_clr, tmo_en, tmo_expired;

  mem_bus_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q   <= IDLE;
      req_q     <= '0;
      rd_buf_q  <= ZeroWord;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      rd_buf_q  <= rd_buf_d;
      bus_err_q <= bus_err_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    rd_buf_d   = rd_buf_q;
    bus_err_d  = 1'b0;
    stallreq   = NoStop;
    cpu_data_o = ZeroWord;
    tmo_clr    = 1'b1;
    tmo_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_d    = '0;
        stallreq = cpu_ce_i & ~flush_i;
        if (cpu_ce_i && !flush_i) begin
          req_d = '{adr: cpu_addr_i, dat: cpu_data_i, we: cpu_we_i,
                    sel: cpu_sel_i, stb: 1'b1, cyc: 1'b1};
          state_d = BUSY;
        end
      end

      BUSY: begin
        tmo_clr  = 1'b0;
        stallreq = Stop;
        if (flush_i) begin
          // Flush beats a coincident ack: drop the cycle, keep rd_buf.
          stallreq = NoStop;
          req_d    = '0;
          state_d  = IDLE;
        end else if (wb.wb_ack_i || tmo_expired) begin
          // Ack and timeout share one termination path; only the data source
          // and the error pulse differ.
          stallreq   = NoStop;
          cpu_data_o = wb.wb_ack_i ? wb.wb_dat_i : ERR_DATA;
          rd_buf_d   = cpu_data_o;
          bus_err_d  = ~wb.wb_ack_i;
          req_d      = '0;
          state_d    = (|stall_i) ? WAIT_FOR_STALL : IDLE;
        end else begin
          tmo_en = 1'b1;
        end
      end

      WAIT_FOR_STALL: begin
        req_d      = '0;
        cpu_data_o = rd_buf_q;
        if (!(|stall_i)) begin
          state_d = IDLE;
        end
      end

      default: begin
        req_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign wb.wb_adr_o = req_q.adr;
  assign wb.wb_dat_o = req_q.dat;
  assign wb.wb_we_o  = req_q.we;
  assign wb.wb_sel_o = req_q.sel;
  assign wb.wb_stb_o = req_q.stb;
  assign wb.wb_cyc_o = req_q.cyc;
  assign bus_err_o   = bus_err_q;

endmodule

// File: tb/tb_mem_wb_bus_master.sv
// Self-checking bench for mem_wb_bus_master. Completed bus cycles are checked
// by a monitor against a queue of expected transactions and load data;
// cycle-exact behaviour (stall, flush, timeout, reset) is checked inline.
module tb_mem_wb_bus_master;

  localparam int unsigned TO_CYCLES = 8;
  localparam logic [31:0] ERR_WORD  = 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
  } bus_exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        ce;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] cdata;
  logic [31:0] cpu_data;
  logic        stallreq;
  logic        bus_err;

  int total = 0;
  int bad   = 0;

  bus_exp_t    bus_q[$];
  logic [31:0] rd_q[$];

  mem_wb_bus_master_if wb_bus ();

  mem_wb_bus_master #(
    .TIMEOUT_CYCLES (TO_CYCLES),
    .ERR_DATA       (ERR_WORD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall),
    .flush_i    (flush),
    .cpu_ce_i   (ce),
    .cpu_addr_i (addr),
    .cpu_we_i   (we),
    .cpu_sel_i  (sel),
    .cpu_data_i (cdata),
    .cpu_data_o (cpu_data),
    .stallreq   (stallreq),
    .bus_err_o  (bus_err),
    .wb         (wb_bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Drives a request for one cycle; pushes the expected bus transaction when
  // the access is supposed to complete on the bus.
  task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] s,
                       input logic [31:0] d, input bit expect_done);
    bus_exp_t e;
    ce = 1'b1; addr = a; we = w; sel = s; cdata = d;
    if (expect_done) begin
      e.adr = a; e.dat = d; e.we = w; e.sel = s;
      bus_q.push_back(e);
    end
  endtask

  task automatic check_idle_bus(input string tag);
    check({tag, " stb"}, 32'(wb_bus.wb_stb_o), 0);
    check({tag, " cyc"}, 32'(wb_bus.wb_cyc_o), 0);
    check({tag, " we"},  32'(wb_bus.wb_we_o), 0);
    check({tag, " sel"}, 32'(wb_bus.wb_sel_o), 0);
    check({tag, " adr"}, wb_bus.wb_adr_o, 0);
  endtask

  // Monitor: every acked, unflushed strobe is a completed transaction.
  always @(negedge clk) begin
    if (!rst && wb_bus.wb_stb_o && wb_bus.wb_cyc_o && wb_bus.wb_ack_i && !flush) begin
      if (bus_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mon unexpected ack: adr %h with no expected transaction", wb_bus.wb_adr_o);
      end else begin
        bus_exp_t e;
        e = bus_q.pop_front();
        check("mon adr", wb_bus.wb_adr_o, e.adr);
        check("mon dat_o", wb_bus.wb_dat_o, e.dat);
        check("mon we", 32'(wb_bus.wb_we_o), 32'(e.we));
        check("mon sel", 32'(wb_bus.wb_sel_o), 32'(e.sel));
        check("mon stallreq in ack", 32'(stallreq), 0);
        if (!e.we) begin
          if (rd_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL mon load: no expected read data for adr %h", e.adr);
          end else begin
            check("mon load data", cpu_data, rd_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0; ce = 1'b0; addr = '0; we = 1'b0;
    sel = '0; cdata = '0; wb_bus.wb_ack_i = 1'b0; wb_bus.wb_dat_i = '0;
    step(); step();

    // Reset state
    at_neg();
    check_idle_bus("reset");
    check("reset dat_o", wb_bus.wb_dat_o, 0);
    check("reset stallreq", 32'(stallreq), 0);
    check("reset bus_err", 32'(bus_err), 0);
    check("reset cpu_data", cpu_data, 0);
    step();
    rst = 1'b0;

    // Load, ack in the third BUSY cycle, no stall
    issue(32'h0000_0100, 1'b0, 4'hF, 32'h0, 1'b1);
    rd_q.push_back(32'hCAFE_BABE);
    at_neg();
    check("t1 idle stallreq", 32'(stallreq), 1);
    check("t1 idle stb", 32'(wb_bus.wb_stb_o), 0);
    step();
    ce = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      at_neg();
      check("t1 busy stb", 32'(wb_bus.wb_stb_o), 1);
      check("t1 busy stallreq", 32'(stallreq), 1);
      check("t1 busy cpu_data", cpu_data, 0);
      step();
    end
    wb_bus.wb_ack_i = 1'b1; wb_bus.wb_dat_i = 32'hCAFE_BABE;
    at_neg();
    step();
    wb_bus.wb_ack_i = 1'b0; wb_bus.wb_dat_i = 32'h0;
    at_neg();
    check_idle_bus("t1 after");
    check("t1 after stallreq", 32'(stallreq), 0);
    check("t1 after cpu_data", cpu_data, 0);
    step();

    // Store, ack in the first BUSY cycle
    issue(32'h0000_0200, 1'b1, 4'b0011, 32'h1234_5678, 1'b1);
    step();
    ce = 1'b0;
    wb_bus.wb_ack_i = 1'b1;
    at_neg();
    step();
    wb_bus.wb_ack_i = 1'b0;
    at_neg();
    check_idle_bus("t2 after");
    check("t2 after cpu_data", cpu_data, 0);
    step();

    // Load acked under an external stall; data held in WAIT_FOR_STALL
    issue(32'h0000_0300, 1'b0, 4'hF, 32'h0, 1'b1);
    rd_q.push_back(32'hA5A5_A5A5);
    step();
    ce = 1'b0;
    wb_bus.wb_ack_i = 1'b1; wb_bus.wb_dat_i = 32'hA5A5_A5A5; stall = 6'b000011;
    at_neg();
    step();
    wb_bus.wb_ack_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wb_bus.wb_dat_i = $urandom;
      ce = 1'b1;
      at_neg();
      check("t3 wait cpu_data", cpu_data, 32'hA5A5_A5A5);
      check("t3 wait stallreq", 32'(stallreq), 0);
      check("t3 wait stb", 32'(wb_bus.wb_stb_o), 0);
      step();
    end
    ce = 1'b0; stall = '0;
    at_neg();
    check("t3 release cpu_data", cpu_data, 32'hA5A5_A5A5);
    step();
    at_neg();
    check("t3 idle cpu_data", cpu_data, 0);
    check("t3 idle stb", 32'(wb_bus.wb_stb_o), 0);
    step();

    // Flush in the second BUSY cycle, without and with a coincident ack
    for (int k = 0; k < 2; k++) begin
      issue(32'h0000_0400 + 32'(k), 1'b0, 4'hF, 32'h0, 1'b0);
      step();
      ce = 1'b0;
      at_neg();
      check("t4 busy stallreq", 32'(stallreq), 1);
      step();
      flush = 1'b1;
      if (k == 1) begin
        wb_bus.wb_ack_i = 1'b1; wb_bus.wb_dat_i = 32'h1111_2222; stall = 6'b000001;
      end
      at_neg();
      check("t4 flush stallreq", 32'(stallreq), 0);
      check("t4 flush cpu_data", cpu_data, 0);
      step();
      flush = 1'b0; wb_bus.wb_ack_i = 1'b0;
      at_neg();
      check("t4 after stb", 32'(wb_bus.wb_stb_o), 0);
      check("t4 after cyc", 32'(wb_bus.wb_cyc_o), 0);
      check("t4 after bus_err", 32'(bus_err), 0);
      check("t4 after cpu_data", cpu_data, 0);
      check("t4 after stallreq", 32'(stallreq), 0);
      step();
      stall = '0;
    end

    // Timeout: no ack for TO_CYCLES BUSY cycles
    issue(32'h0000_0500, 1'b0, 4'hF, 32'h0, 1'b0);
    step();
    ce = 1'b0;
    for (int i = 1; i < int'(TO_CYCLES); i++) begin
      at_neg();
      check("t5 busy stb", 32'(wb_bus.wb_stb_o), 1);
      check("t5 busy stallreq", 32'(stallreq), 1);
      check("t5 busy bus_err", 32'(bus_err), 0);
      step();
    end
    at_neg();
    check("t5 expiry stb", 32'(wb_bus.wb_stb_o), 1);
    check("t5 expiry stallreq", 32'(stallreq), 0);
    check("t5 expiry cpu_data", cpu_data, ERR_WORD);
    step();
    at_neg();
    check("t5 after stb", 32'(wb_bus.wb_stb_o), 0);
    check("t5 after cyc", 32'(wb_bus.wb_cyc_o), 0);
    check("t5 err pulse", 32'(bus_err), 1);
    check("t5 after cpu_data", cpu_data, 0);
    step();
    at_neg();
    check("t5 err cleared", 32'(bus_err), 0);
    step();

    // Reset mid-BUSY, then a late ack that must be ignored
    issue(32'h0000_0600, 1'b1, 4'hC, 32'h5555_AAAA, 1'b0);
    step();
    ce = 1'b0;
    at_neg();
    check("t6 busy stb", 32'(wb_bus.wb_stb_o), 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    at_neg();
    check_idle_bus("t6 reset");
    check("t6 reset dat_o", wb_bus.wb_dat_o, 0);
    check("t6 reset stallreq", 32'(stallreq), 0);
    step();
    wb_bus.wb_ack_i = 1'b1; wb_bus.wb_dat_i = 32'h7777_8888;
    at_neg();
    check("t6 late ack stallreq", 32'(stallreq), 0);
    check("t6 late ack cpu_data", cpu_data, 0);
    step();
    wb_bus.wb_ack_i = 1'b0;
    issue(32'h0000_0700, 1'b0, 4'hF, 32'h0, 1'b1);
    rd_q.push_back(32'h0BAD_F00D);
    at_neg();
    check("t6 new req stallreq", 32'(stallreq), 1);
    step();
    ce = 1'b0;
    wb_bus.wb_ack_i = 1'b1; wb_bus.wb_dat_i = 32'h0BAD_F00D;
    at_neg();
    step();
    wb_bus.wb_ack_i = 1'b0;
    at_neg();
    check("t6 final stb", 32'(wb_bus.wb_stb_o), 0);
    step();

    check("leftover bus transactions", bus_q.size(), 0);
    check("leftover load data", rd_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_bus_master.md
Name: mem_wb_bus_master

Overview:
Data-side Wishbone master at the downstream end of the EX/MEM register: it consumes the memory-stage load/store request (address, byte selects, store data) and runs a multi-cycle bus transaction for it. It raises stallreq to the pipeline controller until the access completes, then presents read data to the memory stage. It holds that data stable while the pipeline stays frozen by other stall sources. It also aborts cleanly on a pipeline flush.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in BUSY without ack before forced termination (1..255; counter is 8 bits)
ERR_DATA, 32'h0000_0000, read data returned on timeout

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high (RstEnable)
stall_i  input  6  pipeline stall vector from controller
flush_i  input  1  pipeline flush
cpu_ce_i  input  1  memory-stage access request
cpu_addr_i  input  32  byte address
cpu_we_i  input  1  1 = store, 0 = load
cpu_sel_i  input  4  byte lane selects
cpu_data_i  input  32  store data
cpu_data_o  output  32  load data to memory stage
stallreq  output  1  stall request to controller
bus_err_o  output  1  one-cycle pulse on timeout
wb_adr_o  output  32  Wishbone address
wb_dat_o  output  32  Wishbone write data
wb_we_o  output  1  Wishbone write enable
wb_sel_o  output  4  Wishbone byte selects
wb_stb_o  output  1  Wishbone strobe
wb_cyc_o  output  1  Wishbone cycle
wb_dat_i  input  32  Wishbone read data
wb_ack_i  input  1  Wishbone acknowledge

Behaviour:
- States: IDLE, BUSY, WAIT_FOR_STALL; 2-bit encoding lives in the package.
- Reset (sync, rst=1): state=IDLE. All wb_* outputs = 0, rd_buf = 0, timeout count = 0, bus_err_o = 0. Reset overrides everything, including a transaction in progress; no ack is awaited.
- IDLE:
  - If cpu_ce_i=1 and flush_i=0, on the next edge latch addr/data/we/sel onto wb_*, set stb=cyc=1, clear count, go BUSY.
  - Otherwise wb_* are held at 0.
- BUSY, wb_ack_i=1 with flush_i=0:
  - Next edge: stb=cyc=we=sel=0 and rd_buf <= wb_dat_i.
  - Next state is WAIT_FOR_STALL if stall_i != 0, else IDLE.
- BUSY, flush_i=1: abort. Next edge stb=cyc=0, go IDLE, rd_buf unchanged, no bus_err_o. Flush wins over a simultaneous ack.
- BUSY, count reaches TIMEOUT_CYCLES-1 with no ack:
  - Terminate as if acked, with rd_buf <= ERR_DATA.
  - bus_err_o = 1 for exactly the following cycle.
  - Next state follows the same stall_i rule as an ack.
- BUSY, otherwise: count increments; all wb_* are held constant (Wishbone classic rule).
- WAIT_FOR_STALL: go IDLE on the first edge where stall_i == 0. A new cpu_ce_i is ignored while in this state.
- stallreq (combinational):
  - IDLE: equals cpu_ce_i & ~flush_i.
  - BUSY: 1, except 0 in the ack cycle, the timeout cycle, or when flush_i=1.
  - WAIT_FOR_STALL: 0.
- cpu_data_o (combinational):
  - BUSY with ack: wb_dat_i (zero-latency forward).
  - BUSY at timeout: ERR_DATA.
  - WAIT_FOR_STALL: rd_buf.
  - Otherwise: 0.
- Stores: cpu_data_o is don't-care; the bench checks only that it is 0 outside an ack cycle.
- Latency: a request issued in cycle n yields stb in n+1. With an ack in cycle n+k, stallreq drops in n+k and data is valid in n+k.
- Back-to-back: after return to IDLE, a new cpu_ce_i starts a transaction on the next edge. There are no idle bus cycles beyond the one IDLE cycle.

Decomposition:
- Shared package/defines: the state encodings, ZeroWord, RstEnable, and the Stop/NoStop constants.
- Reuse the existing Wishbone width defines.
- Sub-module: mem_bus_timeout (8-bit saturating counter with clear/enable and expiry flag). The FSM stays in this module.

Test Plan:
- Load, ack after 3 cycles, stall_i=0: addr 0x100, wb_dat_i=0xCAFEBABE -> stb high in cycles 1-3, stallreq=1 until the ack cycle, cpu_data_o=0xCAFEBABE in that cycle, IDLE next.
- Store, sel=4'b0011, data 0x12345678, ack after 1 cycle -> wb_we_o=1, wb_sel_o=3, wb_dat_o=0x12345678 stable through the ack, cyc=0 afterwards.
- Load acked while stall_i=6'b000011 held 4 more cycles, wb_dat_i=0xA5A5A5A5 -> WAIT_FOR_STALL, cpu_data_o=0xA5A5A5A5 for all 4 cycles with wb_dat_i randomised, stallreq=0, IDLE when stall_i=0.
- flush_i=1 in 2nd BUSY cycle, with and without a simultaneous ack -> stb=cyc=0 next edge, IDLE, bus_err_o=0, stallreq=0 in the flush cycle.
- No ack with TIMEOUT_CYCLES=8 -> stb deasserts after exactly 8 BUSY cycles, cpu_data_o=ERR_DATA, bus_err_o pulses once.
- rst=1 mid-BUSY -> next edge all wb_* = 0, state IDLE. A late ack afterwards is ignored, with stallreq tracking cpu_ce_i only.
